regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
Shares the integer physical regfile's READPORT_NUM read ports among REQ_NUM issue-queue select slots, each needing up to NUMSRCS source operands. A round-robin, all-or-nothing port allocator drives the regfile read indices. Returned data/ready bits are routed back to the granted requesters one cycle later, matching the regfile's registered read latency. Sits between the issue queues and the regfile; physical register 0 is hardwired zero and never consumes a port.

Parameters:
REQ_NUM, 4, number of requesting issue slots
READPORT_NUM, 6, regfile read ports managed (must be >= NUMSRCS)
NUMSRCS, 2, source operands per requester
PRF_SIZE, 80, physical register count; index width IW = $clog2(PRF_SIZE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_flush  in  1  pipeline flush; blocks grants and kills in-flight responses
i_req_vld  in  REQ_NUM  requester i wants its operands read this cycle
i_req_src_vld  in  REQ_NUM*NUMSRCS  bit i*NUMSRCS+s: source s of requester i used
i_req_src_idx  in  IW x REQ_NUM*NUMSRCS  physical index per source
o_gnt  out  REQ_NUM  combinational grant, same cycle as request
o_read_idx  out  IW x READPORT_NUM  to regfile read index ports
i_read_data  in  XLEN x READPORT_NUM  regfile read data (1-cycle latency)
i_data_rdy  in  READPORT_NUM  regfile ready bits (1-cycle latency)
o_rsp_vld  out  REQ_NUM  operands for requester i valid this cycle
o_rsp_data  out  XLEN x REQ_NUM*NUMSRCS  per-source operand data
o_rsp_rdy  out  REQ_NUM*NUMSRCS  per-source ready bit
o_conflict_cnt  out  32  saturating count of cycles with >=1 denied valid requester

Behaviour:
- Need(i) = number of sources s with src_vld set and idx != 0; Need 0 with req_vld still gets a grant and a response, using no ports.
- Scan requesters circularly from rr_ptr. Grant i iff req_vld[i] and remaining ports >= Need(i); otherwise deny i and keep scanning (smaller later requests may still fit). Ports are assigned consecutively from port 0 in scan order, source order within a requester.
- Unassigned ports drive o_read_idx = 0.
- rr_ptr update (registered, only when any req_vld and no flush): if any valid requester was denied, rr_ptr <= first denied in scan order; else rr_ptr <= (rr_ptr+1) mod REQ_NUM. The head is always granted (Need <= NUMSRCS <= READPORT_NUM), so there is no starvation.
- Stage 1 registers: rsp_vld, plus per source a port number and a zero flag. At T+1, o_rsp_vld[i] = 1 for each grant at T.
  - Zero-flag or unused sources: data 0, rdy 1.
  - Otherwise data = i_read_data[port], rdy = i_data_rdy[port].
  - o_rsp_data/o_rsp_rdy are don't-care when o_rsp_vld is low. Drive 0 for determinism.
- Flush at T: o_gnt forced 0 at T; rr_ptr and conflict counter hold; registered rsp_vld cleared at T+1, so responses granted at T-1 are still delivered at T and T's own grants are nonexistent.
- o_conflict_cnt increments when any requester is denied (no flush) and saturates at 0xFFFFFFFF.
- Reset (rst low, asynchronous): rr_ptr=0, rsp_vld=0, port map=0, conflict cnt=0. While rst is low, o_gnt=0, o_read_idx all 0, and o_rsp_vld=0. Reset deasserting mid-request: the first grant evaluates on the first clock edge after release.

Test Plan:
- Single requester 0, srcs idx 5 and 9, i_read_data = {0xA, 0xB} on ports 0/1 at T+1 -> o_gnt=0001 at T; o_read_idx[0]=5, [1]=9; o_rsp_vld[0]=1 and data {0xA,0xB} at T+1.
- All 4 requesters, 2 nonzero srcs each, READPORT_NUM=6, rr_ptr=0 -> grants 0,1,2, deny 3; next cycle rr_ptr=3 and requester 3 is granted first on ports 0/1; conflict_cnt=1.
- Requester 1 needs 2, requester 2 needs 1, 1 port left after requester 0 -> requester 1 denied, requester 2 granted port 2; rr_ptr <= 1.
- Requester with src idx 0 and idx 0 -> granted, no ports used, o_rsp_data 0 and o_rsp_rdy 1 at T+1.
- Grant at T, i_flush at T+1 with new requests -> response from T delivered at T+1, o_gnt=0 at T+1, no o_rsp_vld at T+2.
- Assert rst low mid-stream with rsp_vld pending -> o_rsp_vld drops immediately (asynchronous), rr_ptr=0 after release.

Source files
------------

// File: rtl/regfile_read_arbiter_if.sv
// regfile_read_arbiter_if: issue-queue / regfile bundle for the read-port arbiter
interface regfile_read_arbiter_if #(
    parameter int REQ_NUM      = 4,
    parameter int READPORT_NUM = 6,
    parameter int NUMSRCS      = 2,
    parameter int PRF_SIZE     = 80,
    parameter int XLEN         = 64
);
    localparam int IW = $clog2(PRF_SIZE);
    localparam int SN = REQ_NUM * NUMSRCS;
    logic                               i_flush;
    logic [REQ_NUM-1:0]                 i_req_vld;
    logic [SN-1:0]                      i_req_src_vld;
    logic [SN-1:0][IW-1:0]              i_req_src_idx;
    logic [REQ_NUM-1:0]                 o_gnt;
    logic [READPORT_NUM-1:0][IW-1:0]    o_read_idx;
    logic [READPORT_NUM-1:0][XLEN-1:0]  i_read_data;
    logic [READPORT_NUM-1:0]            i_data_rdy;
    logic [REQ_NUM-1:0]                 o_rsp_vld;
    logic [SN-1:0][XLEN-1:0]            o_rsp_data;
    logic [SN-1:0]                      o_rsp_rdy;
    logic [31:0]                        o_conflict_cnt;
    modport slave (
        input  i_flush, i_req_vld, i_req_src_vld, i_req_src_idx, i_read_data, i_data_rdy,
        output o_gnt, o_read_idx, o_rsp_vld, o_rsp_data, o_rsp_rdy, o_conflict_cnt
    );
    modport master (
        output i_flush, i_req_vld, i_req_src_vld, i_req_src_idx, i_read_data, i_data_rdy,
        input  o_gnt, o_read_idx, o_rsp_vld, o_rsp_data, o_rsp_rdy, o_conflict_cnt
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin all-or-nothing sharing of regfile read ports among issue slots
module regfile_read_arbiter #(
    parameter int REQ_NUM      = 4,
    parameter int READPORT_NUM = 6,
    parameter int NUMSRCS      = 2,
    parameter int PRF_SIZE     = 80,
    parameter int XLEN         = 64
) (
    input logic clk,
    input logic rst,
    regfile_read_arbiter_if.slave bus
);
    localparam int IW = $clog2(PRF_SIZE);
    localparam int SN = REQ_NUM * NUMSRCS;
    localparam int PW = READPORT_NUM > 1 ? $clog2(READPORT_NUM) : 1;
    localparam int RW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
    logic [RW-1:0]                    rr_ptr, first_den, j;
    logic [RW:0]                      pos;
    logic [PW:0]                      used, need;
    logic                             denied;
    logic [REQ_NUM-1:0]               gnt_raw, rsp_vld;
    logic [READPORT_NUM-1:0][IW-1:0]  read_idx;
    logic [SN-1:0][PW-1:0]            src_port, port_q;
    logic [SN-1:0]                    src_zero, zero_q;
    logic [31:0]                      conflict_cnt;
    // circular scan from rr_ptr: grant whole requesters that fit, pack their nonzero sources onto ports in order
    always_comb begin
        gnt_raw = '0;
        read_idx = '0;
        src_port = '0;
        src_zero = '1;
        denied = 1'b0;
        first_den = rr_ptr;
        used = '0;
        need = '0;
        pos = '0;
        j = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            pos = {1'b0, rr_ptr} + (RW+1)'(k);
            j = (pos >= (RW+1)'(REQ_NUM)) ? RW'(pos - (RW+1)'(REQ_NUM)) : pos[RW-1:0];
            need = '0;
            for (int s = 0; s < NUMSRCS; s++)
                need = need + (PW+1)'(bus.i_req_src_vld[j*NUMSRCS+s] && bus.i_req_src_idx[j*NUMSRCS+s] != '0);
            if (bus.i_req_vld[j] && used + need <= (PW+1)'(READPORT_NUM)) begin
                gnt_raw[j] = 1'b1;
                for (int s = 0; s < NUMSRCS; s++)
                    if (bus.i_req_src_vld[j*NUMSRCS+s] && bus.i_req_src_idx[j*NUMSRCS+s] != '0) begin
                        read_idx[used[PW-1:0]] = bus.i_req_src_idx[j*NUMSRCS+s];
                        src_port[j*NUMSRCS+s] = used[PW-1:0];
                        src_zero[j*NUMSRCS+s] = 1'b0;
                        used = used + 1'b1;
                    end
            end else if (bus.i_req_vld[j] && !denied) begin
                denied = 1'b1;
                first_den = j;
            end
        end
    end
    assign bus.o_gnt = (rst && !bus.i_flush) ? gnt_raw : '0;
    assign bus.o_read_idx = rst ? read_idx : '0;
    assign bus.o_rsp_vld = rsp_vld;
    assign bus.o_conflict_cnt = conflict_cnt;
    // stage-1 port map, round-robin pointer and saturating conflict counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            rsp_vld <= '0;
            port_q <= '0;
            zero_q <= '0;
            conflict_cnt <= '0;
        end else begin
            rsp_vld <= bus.o_gnt;
            port_q <= src_port;
            zero_q <= src_zero;
            if (|bus.i_req_vld && !bus.i_flush) begin
                rr_ptr <= denied ? first_den : (rr_ptr == RW'(REQ_NUM-1) ? '0 : rr_ptr + 1'b1);
                if (denied && conflict_cnt != '1)
                    conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
    for (genvar n = 0; n < SN; n++) begin : g_rsp
        assign bus.o_rsp_data[n] = (rsp_vld[n/NUMSRCS] && !zero_q[n]) ? bus.i_read_data[port_q[n]] : '0;
        assign bus.o_rsp_rdy[n] = rsp_vld[n/NUMSRCS] && (zero_q[n] || bus.i_data_rdy[port_q[n]]);
    end
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed and table-driven checks of the read-port arbiter against a behavioural model
module tb_regfile_read_arbiter;
    localparam int RN = 4;
    localparam int RP = 6;
    localparam int NS = 2;
    localparam int PRF = 80;
    localparam int XL = 64;
    localparam int IW = $clog2(PRF);
    localparam int SN = RN * NS;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errs = 0;
    int checks = 0;
    int m_rr;
    logic [31:0] m_cnt;
    logic [RN-1:0] m_pvld;
    int m_pport[SN];
    logic [RN-1:0] e_gnt;
    logic [IW-1:0] e_idx[RP];
    int e_port[SN];
    bit e_den;
    int e_first;
    always #5 clk = ~clk;
    regfile_read_arbiter_if #(.REQ_NUM(RN), .READPORT_NUM(RP), .NUMSRCS(NS), .PRF_SIZE(PRF), .XLEN(XL)) bus ();
    regfile_read_arbiter #(.REQ_NUM(RN), .READPORT_NUM(RP), .NUMSRCS(NS), .PRF_SIZE(PRF), .XLEN(XL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic model_reset();
        m_rr = 0;
        m_cnt = '0;
        m_pvld = '0;
        foreach (m_pport[n]) m_pport[n] = -1;
    endtask
    // what the grant/port outputs must be this cycle
    task automatic model_comb();
        int used;
        int i;
        int need;
        e_gnt = '0;
        e_den = 0;
        e_first = m_rr;
        used = 0;
        foreach (e_idx[p]) e_idx[p] = '0;
        foreach (e_port[n]) e_port[n] = -1;
        for (int k = 0; k < RN; k++) begin
            i = (m_rr + k) % RN;
            need = 0;
            if (bus.i_req_vld[i]) begin
                for (int s = 0; s < NS; s++)
                    if (bus.i_req_src_vld[i*NS+s] && bus.i_req_src_idx[i*NS+s] != 0) need++;
                if (used + need <= RP) begin
                    e_gnt[i] = 1'b1;
                    for (int s = 0; s < NS; s++)
                        if (bus.i_req_src_vld[i*NS+s] && bus.i_req_src_idx[i*NS+s] != 0) begin
                            e_idx[used] = bus.i_req_src_idx[i*NS+s];
                            e_port[i*NS+s] = used;
                            used++;
                        end
                end else if (!e_den) begin
                    e_den = 1;
                    e_first = i;
                end
            end
        end
        if (bus.i_flush || !rst) e_gnt = '0;
        if (!rst) foreach (e_idx[p]) e_idx[p] = '0;
    endtask
    task automatic look();
        logic [63:0] ed;
        logic er;
        @(negedge clk);
        model_comb();
        chk("gnt", 64'(bus.o_gnt), 64'(e_gnt));
        for (int p = 0; p < RP; p++) chk($sformatf("read_idx[%0d]", p), 64'(bus.o_read_idx[p]), 64'(e_idx[p]));
        chk("rsp_vld", 64'(bus.o_rsp_vld), 64'(m_pvld));
        for (int n = 0; n < SN; n++) begin
            ed = '0;
            er = 1'b0;
            if (m_pvld[n/NS]) begin
                if (m_pport[n] < 0) er = 1'b1;
                else begin
                    ed = bus.i_read_data[m_pport[n]];
                    er = bus.i_data_rdy[m_pport[n]];
                end
            end
            chk($sformatf("rsp_data[%0d]", n), bus.o_rsp_data[n], ed);
            chk($sformatf("rsp_rdy[%0d]", n), 64'(bus.o_rsp_rdy[n]), 64'(er));
        end
        chk("conflict_cnt", 64'(bus.o_conflict_cnt), 64'(m_cnt));
    endtask
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pvld = e_gnt;
            foreach (m_pport[n]) m_pport[n] = e_port[n];
            if (|bus.i_req_vld && !bus.i_flush) begin
                if (e_den) begin
                    m_rr = e_first;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end else m_rr = (m_rr + 1) % RN;
            end
        end
        #1;
    endtask
    task automatic clr();
        bus.i_flush = 1'b0;
        bus.i_req_vld = '0;
        bus.i_req_src_vld = '0;
        bus.i_req_src_idx = '0;
    endtask
    task automatic req(int i, bit v0, int x0, bit v1, int x1);
        bus.i_req_vld[i] = 1'b1;
        bus.i_req_src_vld[i*NS] = v0;
        bus.i_req_src_idx[i*NS] = IW'(x0);
        bus.i_req_src_vld[i*NS+1] = v1;
        bus.i_req_src_idx[i*NS+1] = IW'(x1);
    endtask
    task automatic all_four();
        clr();
        for (int i = 0; i < RN; i++) req(i, 1, 10 + 2*i, 1, 11 + 2*i);
    endtask
    initial begin
        model_reset();
        clr();
        bus.i_read_data = '0;
        bus.i_data_rdy = '1;
        req(0, 1, 5, 1, 9);
        #2;
        chk("reset gnt", 64'(bus.o_gnt), 64'h0);
        chk("reset read_idx0", 64'(bus.o_read_idx[0]), 64'h0);
        chk("reset rsp_vld", 64'(bus.o_rsp_vld), 64'h0);
        chk("reset cnt", 64'(bus.o_conflict_cnt), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // all four want two ports: 0,1,2 fit, 3 denied
        all_four();
        look();
        chk("lit all gnt", 64'(bus.o_gnt), 64'h7);
        chk("lit all idx4", 64'(bus.o_read_idx[4]), 64'd14);
        tick();
        look();
        chk("lit rr3 gnt", 64'(bus.o_gnt), 64'hB);
        chk("lit rr3 idx0", 64'(bus.o_read_idx[0]), 64'd16);
        chk("lit rr3 idx1", 64'(bus.o_read_idx[1]), 64'd17);
        chk("lit cnt1", 64'(bus.o_conflict_cnt), 64'd1);
        tick();
        // rr=2: 2,3 take four ports, 0 takes one, 1 needs two and is denied
        clr();
        req(2, 1, 20, 1, 21);
        req(3, 1, 22, 1, 23);
        req(0, 1, 24, 0, 0);
        req(1, 1, 25, 1, 26);
        look();
        chk("lit partial gnt", 64'(bus.o_gnt), 64'hD);
        chk("lit partial idx4", 64'(bus.o_read_idx[4]), 64'd24);
        chk("lit partial idx5", 64'(bus.o_read_idx[5]), 64'd0);
        tick();
        // zero-index and unused sources consume no ports
        clr();
        req(1, 1, 0, 1, 0);
        req(3, 0, 33, 0, 44);
        look();
        chk("lit zero gnt", 64'(bus.o_gnt), 64'hA);
        chk("lit zero idx0", 64'(bus.o_read_idx[0]), 64'd0);
        tick();
        clr();
        for (int p = 0; p < RP; p++) bus.i_read_data[p] = 64'hDEAD_0000 + 64'(p);
        bus.i_data_rdy = '0;
        look();
        chk("lit zero rsp_vld", 64'(bus.o_rsp_vld), 64'hA);
        chk("lit zero data2", bus.o_rsp_data[2], 64'h0);
        chk("lit zero rdy", 64'(bus.o_rsp_rdy), 64'hCC);
        tick();
        // single requester 0 with sources 5 and 9
        clr();
        bus.i_data_rdy = '1;
        req(0, 1, 5, 1, 9);
        look();
        chk("lit single gnt", 64'(bus.o_gnt), 64'h1);
        chk("lit single idx0", 64'(bus.o_read_idx[0]), 64'd5);
        chk("lit single idx1", 64'(bus.o_read_idx[1]), 64'd9);
        tick();
        clr();
        bus.i_read_data[0] = 64'hA;
        bus.i_read_data[1] = 64'hB;
        look();
        chk("lit single rsp_vld", 64'(bus.o_rsp_vld), 64'h1);
        chk("lit single data0", bus.o_rsp_data[0], 64'hA);
        chk("lit single data1", bus.o_rsp_data[1], 64'hB);
        tick();
        // flush: earlier grant still delivered, flushed cycle grants nothing
        clr();
        req(2, 1, 3, 1, 4);
        look();
        tick();
        clr();
        req(0, 1, 7, 0, 0);
        bus.i_flush = 1'b1;
        bus.i_read_data[0] = 64'h11;
        bus.i_read_data[1] = 64'h22;
        look();
        chk("lit flush rsp_vld", 64'(bus.o_rsp_vld), 64'h4);
        chk("lit flush data4", bus.o_rsp_data[4], 64'h11);
        chk("lit flush data5", bus.o_rsp_data[5], 64'h22);
        chk("lit flush gnt", 64'(bus.o_gnt), 64'h0);
        tick();
        clr();
        look();
        chk("lit post flush rsp_vld", 64'(bus.o_rsp_vld), 64'h0);
        tick();
        // asynchronous reset with a response pending
        clr();
        req(1, 1, 50, 1, 51);
        look();
        tick();
        chk("lit pending rsp_vld", 64'(bus.o_rsp_vld), 64'h2);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("lit async rsp_vld", 64'(bus.o_rsp_vld), 64'h0);
        chk("lit async gnt", 64'(bus.o_gnt), 64'h0);
        chk("lit async idx0", 64'(bus.o_read_idx[0]), 64'h0);
        look();
        tick();
        rst = 1'b1;
        all_four();
        look();
        chk("lit rr after reset gnt", 64'(bus.o_gnt), 64'h7);
        tick();
        // mixed request/source/flush patterns checked against the model
        for (int c = 0; c < 40; c++) begin
            clr();
            bus.i_req_vld = RN'($urandom);
            bus.i_req_src_vld = SN'($urandom);
            for (int n = 0; n < SN; n++)
                bus.i_req_src_idx[n] = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(1, PRF-1));
            bus.i_flush = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < RP; p++) bus.i_read_data[p] = {$urandom, $urandom};
            bus.i_data_rdy = RP'($urandom);
            look();
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
